sha512_wsched: RTL and testbench

SHA512_WSCHED -- requirements
Module: sha512_wsched

---
 rtl/sha512_wsched.sv | 151 +++++++++++++++
 tb/tb_sha512_wsched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha512_wsched.sv
// sha512_wsched: SHA-512 message schedule generator.
//   Accepts the 16 message words W[0..15] of a block, passes each through to a
//   registered output, then expands W[16..ROUNDS-1] from a 16-entry circular
//   buffer, one word per cycle when the downstream stage keeps up.
// Ports:
//   CLK        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a new block (sampled only in IDLE)
//   din        message word W[t], t = 0..15
//   din_valid  din holds a valid word
//   din_ready  block accepts din this cycle
//   w_out      registered schedule word
//   w_valid    w_out holds a valid word
//   w_ready    downstream consumes w_out this cycle
//   t_out      round index of the word in w_out
//   busy       high in any state but IDLE
//   done       one-cycle pulse after the last word is consumed
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting W[0..15] from din
// EXPAND | computing W[16..ROUNDS-1], then waiting for the last word to drain
module sha512_wsched #(
  parameter int ROUNDS = 80,
  parameter int WIDTH  = 64
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] w_out,
  output logic             w_valid,
  input  logic             w_ready,
  output logic [6:0]       t_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

  localparam logic [6:0] ROUNDS_T = 7'(ROUNDS);
  localparam logic [6:0] LAST_T   = 7'(ROUNDS - 1);

  state_t           state, state_nxt;
  logic [6:0]       t, t_nxt;
  logic [6:0]       t_out_nxt;
  logic [WIDTH-1:0] w_out_nxt;
  logic             w_valid_nxt;
  logic             done_nxt;
  logic             slot_free;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] w_new;
  logic [WIDTH-1:0] wbuf [16];

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
    return (x >> n) | (x << (WIDTH - n));
  endfunction

  function automatic logic [WIDTH-1:0] sig0(input logic [WIDTH-1:0] x);
    return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [WIDTH-1:0] sig1(input logic [WIDTH-1:0] x);
    return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  // Slot t[3:0] still holds W[t-16]; it is read here and overwritten on the
  // same edge that w_new is written.
  assign w_new = sig1(wbuf[t[3:0] + 4'd14]) + wbuf[t[3:0] + 4'd9]
               + sig0(wbuf[t[3:0] + 4'd1]) + wbuf[t[3:0]];

  assign slot_free = !w_valid || w_ready;
  assign din_ready = (state == LOAD) && slot_free;
  assign busy      = (state != IDLE);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      t       <= '0;
      t_out   <= '0;
      w_out   <= '0;
      w_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      t       <= t_nxt;
      t_out   <= t_out_nxt;
      w_out   <= w_out_nxt;
      w_valid <= w_valid_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    t_nxt       = t;
    t_out_nxt   = t_out;
    w_out_nxt   = w_out;
    w_valid_nxt = w_valid;
    done_nxt    = 1'b0;
    wr_en       = 1'b0;
    wr_data     = din;
    // A free slot drains unless something below refills it this cycle.
    if (slot_free) w_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          t_nxt     = '0;
        end
      end
      LOAD: begin
        if (din_valid && din_ready) begin
          w_out_nxt   = din;
          t_out_nxt   = t;
          w_valid_nxt = 1'b1;
          wr_en       = 1'b1;
          wr_data     = din;
          t_nxt       = t + 7'd1;
          if (t == 7'd15) state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        if (t != ROUNDS_T) begin
          if (slot_free) begin
            w_out_nxt   = w_new;
            t_out_nxt   = t;
            w_valid_nxt = 1'b1;
            wr_en       = 1'b1;
            wr_data     = w_new;
            t_nxt       = t + 7'd1;
          end
        end else if (w_valid && w_ready && t_out == LAST_T) begin
          state_nxt   = IDLE;
          w_valid_nxt = 1'b0;
          done_nxt    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Schedule words need no reset: every block rewrites all 16 slots before use.
  always_ff @(posedge CLK) begin
    if (wr_en) wbuf[t[3:0]] <= wr_data;
  end

endmodule

// File: tb/tb_sha512_wsched.sv
module tb_sha512_wsched;
  localparam int ROUNDS = 80;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [63:0] w_out;
  logic        w_valid;
  logic        w_ready = 1'b1;
  logic [6:0]  t_out;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit rdy_rand = 1'b0;
  logic [63:0] exp_w [ROUNDS];

  sha512_wsched #(.ROUNDS(ROUNDS), .WIDTH(64)) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .w_out(w_out), .w_valid(w_valid), .w_ready(w_ready),
    .t_out(t_out), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Full-array reference: W[t] from the textbook recurrence, no circular buffer.
  task automatic build_model(input logic [63:0] m [16]);
    logic [63:0] w [ROUNDS];
    for (int i = 0; i < ROUNDS; i++) begin
      if (i < 16) w[i] = m[i];
      else w[i] = (rr(w[i-2], 19) ^ rr(w[i-2], 61) ^ (w[i-2] >> 6)) + w[i-7]
                + (rr(w[i-15], 1) ^ rr(w[i-15], 8) ^ (w[i-15] >> 7)) + w[i-16];
    end
    for (int i = 0; i < ROUNDS; i++) exp_w[i] = w[i];
  endtask

  // Downstream readiness.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      w_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every consumed word, stall stability and done timing.
  initial begin
    int idx;
    bit pend_done, stalled;
    logic [63:0] prev_w;
    logic [6:0]  prev_t;
    idx = 0; pend_done = 0; stalled = 0; prev_w = '0; prev_t = '0;
    forever begin
      @(negedge CLK);
      if (!rst_n) begin
        idx = 0; pend_done = 0; stalled = 0;
      end else begin
        chk("done", 64'(done), 64'(pend_done));
        if (pend_done) idx = 0;
        pend_done = 0;
        if (stalled) begin
          chk("stall_valid", 64'(w_valid), 64'd1);
          chk("stall_w", w_out, prev_w);
          chk("stall_t", 64'(t_out), 64'(prev_t));
        end
        if (w_valid && w_ready) begin
          if (idx < ROUNDS) begin
            chk($sformatf("w[%0d]", idx), w_out, exp_w[idx]);
            chk($sformatf("t_out[%0d]", idx), 64'(t_out), 64'(idx));
            if (idx == ROUNDS - 1) pend_done = 1;
          end else begin
            chk("extra_word_t", 64'(t_out), 64'hFFFF);
          end
          idx++;
        end
        stalled = w_valid && !w_ready;
        prev_w = w_out;
        prev_t = t_out;
      end
    end
  end

  task automatic start_block(output int t0);
    @(posedge CLK); #1;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  // Caller is just after a rising edge.
  task automatic send_block(input logic [63:0] m [16], input bit gaps);
    bit acc;
    int tries;
    for (int i = 0; i < 16; i++) begin
      acc = 0;
      tries = 0;
      while (!acc) begin
        din_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        din = din_valid ? m[i] : rnd64();
        @(negedge CLK);
        acc = din_valid && din_ready;
        @(posedge CLK); #1;
        tries++;
        if (!acc && tries > 500) begin
          total++; bad++;
          $display("FAIL din_accept_timeout word=%0d actual=0 required=1", i);
          din_valid = 1'b0;
          return;
        end
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic wait_done(output int t1);
    t1 = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (done) begin
        t1 = cyc;
        return;
      end
    end
    total++; bad++;
    $display("FAIL done_timeout actual=0 required=1");
  endtask

  initial begin
    logic [63:0] m [16];
    int t0, t1;
    bit hit;

    // Reset state
    #1;
    chk("rst_w_valid", 64'(w_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_w_out", w_out, 64'd0);
    chk("rst_t_out", 64'(t_out), 64'd0);
    chk("rst_din_ready", 64'(din_ready), 64'd0);
    repeat (3) @(posedge CLK);
    #1 rst_n = 1'b1;
    @(negedge CLK);
    chk("idle_busy", 64'(busy), 64'd0);

    // W[0] = 1: pin model, then run DUT
    for (int i = 0; i < 16; i++) m[i] = '0;
    m[0] = 64'd1;
    build_model(m);
    chk("model_w0_16", exp_w[16], 64'h0000000000000001);
    chk("model_w0_17", exp_w[17], 64'h0);
    chk("model_w0_18", exp_w[18], 64'h0000200000000008);
    start_block(t0);
    send_block(m, 1'b0);
    wait_done(t1);

    // W[1] = 1
    m[0] = '0;
    m[1] = 64'd1;
    build_model(m);
    chk("model_w1_16", exp_w[16], 64'h8100000000000000);
    chk("model_w1_17", exp_w[17], 64'h0000000000000001);
    start_block(t0);
    send_block(m, 1'b0);
    wait_done(t1);

    // All-zero block at full rate: 80 words back to back, done 81 edges after start
    for (int i = 0; i < 16; i++) m[i] = '0;
    build_model(m);
    chk("model_zero_79", exp_w[79], 64'h0);
    start_block(t0);
    send_block(m, 1'b0);
    wait_done(t1);
    chk("zero_block_latency", 64'(t1 - t0), 64'd81);
    chk("after_done_busy", 64'(busy), 64'd0);
    chk("after_done_valid", 64'(w_valid), 64'd0);

    // Random blocks with downstream stalls and input gaps
    rdy_rand = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 16; i++) m[i] = rnd64();
      build_model(m);
      start_block(t0);
      send_block(m, 1'b1);
      wait_done(t1);
    end

    // Reset during EXPAND at t = 40
    rdy_rand = 1'b0;
    for (int i = 0; i < 16; i++) m[i] = rnd64();
    build_model(m);
    start_block(t0);
    send_block(m, 1'b0);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge CLK);
      if (w_valid && t_out == 7'd40) hit = 1;
    end
    chk("reach_t40", 64'(hit), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_w_valid", 64'(w_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_t_out", 64'(t_out), 64'd0);
    repeat (2) @(posedge CLK);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge CLK);
    chk("postrst_busy", 64'(busy), 64'd0);
    chk("postrst_valid", 64'(w_valid), 64'd0);
    for (int i = 0; i < 16; i++) m[i] = '0;
    build_model(m);
    start_block(t0);
    send_block(m, 1'b0);
    wait_done(t1);

    // start held high across two blocks
    rdy_rand = 1'b1;
    for (int i = 0; i < 16; i++) m[i] = rnd64();
    build_model(m);
    @(posedge CLK); #1;
    start = 1'b1;
    send_block(m, 1'b1);
    wait_done(t1);
    chk("held_idle_busy", 64'(busy), 64'd0);
    @(negedge CLK);
    chk("held_reload_busy", 64'(busy), 64'd1);
    chk("held_reload_ready", 64'(din_ready), 64'd1);
    @(posedge CLK); #1;
    send_block(m, 1'b1);
    wait_done(t1);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    chk("final_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
